// File: rtl/alu_issue_stage.sv
// Issue register in front of the 64-bit ALU: latches one decoded beat, resolves
// operand forwarding, decodes the ALU selection code and snoops writeback while held.
module alu_issue_stage #(
  parameter int XLEN  = 64,
  parameter int RADDR = 5,
  parameter int ZREG  = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [10:0]      in_opfunc,
  input  logic [RADDR-1:0] in_rs1,
  input  logic [RADDR-1:0] in_rs2,
  input  logic [RADDR-1:0] in_rd,
  input  logic [XLEN-1:0]  in_rdata1,
  input  logic [XLEN-1:0]  in_rdata2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic             exm_reg_write,
  input  logic [RADDR-1:0] exm_rd,
  input  logic [XLEN-1:0]  exm_result,
  input  logic             mwb_reg_write,
  input  logic [RADDR-1:0] mwb_rd,
  input  logic [XLEN-1:0]  mwb_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_selection,
  output logic [XLEN-1:0]  alu_input1,
  output logic [XLEN-1:0]  alu_input2,
  output logic [XLEN-1:0]  store_data,
  output logic [RADDR-1:0] out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             illegal_op
);

  localparam logic [RADDR-1:0] ZIDX = RADDR'(ZREG);

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_ORR = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;

  localparam logic [10:0] OPF_ADD = 11'b10001011000;
  localparam logic [10:0] OPF_SUB = 11'b11001011000;
  localparam logic [10:0] OPF_AND = 11'b10001010000;
  localparam logic [10:0] OPF_ORR = 11'b10101010000;

  // Handshake: a beat moves on a rising edge where valid && ready on that side.
  // in_ready never looks at in_valid; flush forces it low; out_valid holds the
  // beat (outputs stable apart from snooped operands) until out_ready is seen.
  logic capture;
  logic drain;
  logic hold;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign hold     = out_valid && !out_ready && !flush;

  // Held source indices and immediate flag let a parked beat keep snooping.
  logic [RADDR-1:0] held_rs1;
  logic [RADDR-1:0] held_rs2;
  logic             held_use_imm;

  // EX/MEM beats MEM/WB; the zero register always reads zero.
  function automatic logic [XLEN-1:0] fwd_value(
    input logic [RADDR-1:0] src,
    input logic [XLEN-1:0]  base,
    input logic             e_we,
    input logic [RADDR-1:0] e_rd,
    input logic [XLEN-1:0]  e_res,
    input logic             m_we,
    input logic [RADDR-1:0] m_rd,
    input logic [XLEN-1:0]  m_res
  );
    logic [XLEN-1:0] v;
    v = base;
    if (src == ZIDX) begin
      v = '0;
    end else if (e_we && (e_rd == src) && (e_rd != ZIDX)) begin
      v = e_res;
    end else if (m_we && (m_rd == src) && (m_rd != ZIDX)) begin
      v = m_res;
    end
    return v;
  endfunction

  // Returns {illegal, selection}.
  function automatic logic [4:0] decode(input logic [1:0] op, input logic [10:0] f);
    logic [4:0] r;
    r = {1'b1, SEL_SUB};
    case (op)
      2'b00: r = {1'b0, SEL_ADD};
      2'b01: r = {1'b0, SEL_SUB};
      2'b10: begin
        case (f)
          OPF_ADD: r = {1'b0, SEL_ADD};
          OPF_SUB: r = {1'b0, SEL_SUB};
          OPF_AND: r = {1'b0, SEL_AND};
          OPF_ORR: r = {1'b0, SEL_ORR};
          default: r = {1'b1, SEL_SUB};
        endcase
      end
      default: r = {1'b1, SEL_SUB};
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] cap_op1;
  logic [XLEN-1:0] cap_rs2;
  logic [4:0]      cap_dec;
  logic [XLEN-1:0] snp_op1;
  logic [XLEN-1:0] snp_rs2;

  always_comb begin
    cap_op1 = fwd_value(in_rs1, in_rdata1, exm_reg_write, exm_rd, exm_result,
                        mwb_reg_write, mwb_rd, mwb_result);
    cap_rs2 = fwd_value(in_rs2, in_rdata2, exm_reg_write, exm_rd, exm_result,
                        mwb_reg_write, mwb_rd, mwb_result);
    cap_dec = decode(in_alu_op, in_opfunc);
    // store_data doubles as the raw rs2 copy, since alu_input2 may be the immediate.
    snp_op1 = fwd_value(held_rs1, alu_input1, exm_reg_write, exm_rd, exm_result,
                        mwb_reg_write, mwb_rd, mwb_result);
    snp_rs2 = fwd_value(held_rs2, store_data, exm_reg_write, exm_rd, exm_result,
                        mwb_reg_write, mwb_rd, mwb_result);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_selection <= '0;
      illegal_op    <= 1'b0;
      alu_input1    <= '0;
      alu_input2    <= '0;
      store_data    <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      held_rs1      <= '0;
      held_rs2      <= '0;
      held_use_imm  <= 1'b0;
    end else if (capture) begin
      alu_selection <= cap_dec[3:0];
      illegal_op    <= cap_dec[4];
      alu_input1    <= cap_op1;
      alu_input2    <= in_use_imm ? in_imm : cap_rs2;
      store_data    <= cap_rs2;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write;
      out_mem_read  <= in_mem_read;
      out_mem_write <= in_mem_write;
      held_rs1      <= in_rs1;
      held_rs2      <= in_rs2;
      held_use_imm  <= in_use_imm;
    end else if (hold) begin
      alu_input1 <= snp_op1;
      store_data <= snp_rs2;
      if (!held_use_imm) begin
        alu_input2 <= snp_rs2;
      end
    end
  end

endmodule
